// File: rtl/mdu_opcodes_pkg.sv
// Opcodes, FSM states and shared helpers for the iterative RV32M multiply/divide unit.
// Pure definitions: no latency, no flow control.
package mdu_opcodes_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    localparam int MDU_ITERS = 32;

    // Widened to 33 bits so |0x80000000| comes out as 2^31 without wrapping.
    function automatic logic [32:0] mdu_mag(input logic [31:0] x, input logic s);
        logic [32:0] ext;
        ext = s ? (33'd0 - {x[31], x}) : {1'b0, x};
        return ext;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Zero latency; no flow control.
module mdu_div_step
    import mdu_opcodes_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);

    logic [XLEN:0]   trial;
    logic [XLEN-1:0] diff;

    // The remainder after a successful subtract is below the divisor, so XLEN bits suffice.
    always_comb begin
        trial = {rem_i, bit_i};
        diff  = trial[XLEN-1:0] - divisor_i;
        q_o   = (trial >= {1'b0, divisor_i});
        rem_o = q_o ? diff : trial[XLEN-1:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div: 33-cycle ops, 1-cycle for division special cases (MDU_EARLY_OUT_EN adds zero/early-exit multiply).
// One op in flight: ready_o only in IDLE, req_i ignored otherwise; valid_o is a one-cycle pulse.
module muldiv_unit
    import mdu_opcodes_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic [2:0]      mdu_op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    mdu_state_t        state_q, state_d;
    mdu_op_e           op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;

    mdu_op_e           op_in;
    logic              sa_in, sb_in, neg_in;
    logic [XLEN:0]     mag_a, mag_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_res;
`ifdef MDU_EARLY_OUT_EN
    logic              mul_zero;
`endif

    logic [2*XLEN-1:0] mul_sum, prod_signed;
    logic [XLEN-1:0]   step_rem, quo_next, quo_signed, rem_signed, final_res;
    logic              step_q, last_iter;

    mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i     (acc_q[XLEN-1:0]),
        .bit_i     (opa_q[XLEN-1]),
        .divisor_i (opb_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // Operand decode at accept: signedness per op, magnitudes and result sign.
    always_comb begin
        op_in  = mdu_op_e'(mdu_op_i);
        sa_in  = a_i[XLEN-1] & (op_in == MDU_MUL || op_in == MDU_MULH || op_in == MDU_MULHSU ||
                                op_in == MDU_DIV || op_in == MDU_REM);
        sb_in  = b_i[XLEN-1] & (op_in == MDU_MUL || op_in == MDU_MULH ||
                                op_in == MDU_DIV || op_in == MDU_REM);
        mag_a  = mdu_mag(a_i, sa_in);
        mag_b  = mdu_mag(b_i, sb_in);
        neg_in = (op_in == MDU_REM) ? sa_in : (sa_in ^ sb_in);

        div_zero = op_in[2] && (mag_b == '0);
        div_ovf  = (op_in == MDU_DIV || op_in == MDU_REM) && sa_in && (b_i == '1) &&
                   (mag_a == {2'b01, {(XLEN-1){1'b0}}});
        if (div_zero)
            special_res = op_in[1] ? a_i : '1;
        else
            special_res = op_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
`ifdef MDU_EARLY_OUT_EN
        mul_zero = !op_in[2] && ((mag_a == '0) || (mag_b == '0));
`endif
    end

    // Per-iteration datapath and the signed result that would be produced if this were the last step.
    always_comb begin
        mul_sum     = acc_q + (opb_q[0] ? mcand_q : '0);
        quo_next    = {opa_q[XLEN-2:0], step_q};
        prod_signed = neg_q ? (~mul_sum + 1'b1) : mul_sum;
        quo_signed  = neg_q ? (~quo_next + 1'b1) : quo_next;
        rem_signed  = neg_q ? (~step_rem + 1'b1) : step_rem;
        case (op_q)
            MDU_MUL:                         final_res = prod_signed[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: final_res = prod_signed[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:               final_res = quo_signed;
            default:                         final_res = rem_signed;
        endcase

        last_iter = (cnt_q == CNT_W'(MDU_ITERS - 1));
`ifdef MDU_EARLY_OUT_EN
        if (!op_q[2] && ((opb_q >> 1) == '0))
            last_iter = 1'b1;
`endif
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    op_d    = op_in;
                    neg_d   = neg_in;
                    cnt_d   = '0;
                    acc_d   = '0;
                    mcand_d = {{XLEN{1'b0}}, mag_a[XLEN-1:0]};
                    opa_d   = mag_a[XLEN-1:0];
                    opb_d   = mag_b[XLEN-1:0];
                    if (div_zero || div_ovf) begin
                        state_d  = DONE;
                        result_d = special_res;
                    end
`ifdef MDU_EARLY_OUT_EN
                    else if (mul_zero) begin
                        state_d  = DONE;
                        result_d = '0;
                    end
`endif
                    else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q[2]) begin
                    acc_d = {{XLEN{1'b0}}, step_rem};
                    opa_d = quo_next;
                end else begin
                    acc_d   = mul_sum;
                    mcand_d = mcand_q << 1;
                    opb_d   = opb_q >> 1;
                end
                if (last_iter) begin
                    state_d  = DONE;
                    result_d = final_res;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= MDU_MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
        end
    end

    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, special cases, abort, back-to-back, random ops.
// Expected results come from 64-bit integer arithmetic on the RISC-V definitions.
module tb_muldiv_unit;
    import mdu_opcodes_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic [2:0]  mdu_op_i = 3'd0;
    logic [31:0] a_i = 32'd0;
    logic [31:0] b_i = 32'd0;
    logic        ready_o, valid_o;
    logic [31:0] result_o;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .mdu_op_i (mdu_op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .ready_o  (ready_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 0;
        case (op)
            MDU_MUL:    begin p = sa * sb; return p[31:0];  end
            MDU_MULH:   begin p = sa * sb; return p[63:32]; end
            MDU_MULHSU: begin p = sa * ub; return p[63:32]; end
            MDU_MULHU:  begin p = ua * ub; return p[63:32]; end
            MDU_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            MDU_DIVU: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            MDU_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Edges from accept to the sample where valid_o is high.
    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
        longint ma, mb;
`endif
        if (op[2]) begin
            if (b == 32'd0) return 0;
            if ((op == MDU_DIV || op == MDU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
            return 32;
        end
`ifdef MDU_EARLY_OUT_EN
        ma = (op != MDU_MULHU) ? longint'(signed'(a)) : longint'({32'd0, a});
        mb = (op == MDU_MUL || op == MDU_MULH) ? longint'(signed'(b)) : longint'({32'd0, b});
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        if (ma == 0 || mb == 0) return 0;
        for (int i = 31; i >= 0; i--)
            if (mb[i]) return i + 1;
`endif
        return 32;
    endfunction

    // Issue one op from an IDLE cycle, return its result/latency and whether ready_o stayed low.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output bit rdy_low);
        req_i = 1'b1; mdu_op_i = op; a_i = a; b_i = b;
        @(posedge clk_i); #1;
        req_i = 1'b0; mdu_op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
        rdy_low = 1'b1; lat = -1; res = 'x;
        for (int n = 0; n < 100; n++) begin
            if (valid_o) begin lat = n; res = result_o; break; end
            if (ready_o) rdy_low = 1'b0;
            @(posedge clk_i); #1;
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        tests_run++;
        if (ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", ready_o); end
        tests_run++;
        if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", valid_o); end
        tests_run++;
        if (result_o !== 32'd0) begin tests_failed++; $display("FAIL reset_result got %h want 0", result_o); end
        rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_directed();
        vec_t v[12];
        logic [31:0] res;
        int lat;
        bit rl;
        v[0]  = '{MDU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        v[1]  = '{MDU_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        v[2]  = '{MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        v[3]  = '{MDU_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
        v[4]  = '{MDU_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        v[5]  = '{MDU_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        v[6]  = '{MDU_DIVU,   32'd100,        32'd7,         32'd14};
        v[7]  = '{MDU_REMU,   32'd100,        32'd7,         32'd2};
        v[8]  = '{MDU_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF};
        v[9]  = '{MDU_REM,    32'd5,          32'd0,         32'd5};
        v[10] = '{MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        v[11] = '{MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        for (int i = 0; i < 12; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, res, lat, rl);
            tests_run++;
            if (res !== v[i].exp) begin
                tests_failed++;
                $display("FAIL directed_result[%0d] op=%0d got %h want %h", i, v[i].op, res, v[i].exp);
            end
            tests_run++;
            if (lat != exp_lat(v[i].op, v[i].a, v[i].b)) begin
                tests_failed++;
                $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, exp_lat(v[i].op, v[i].a, v[i].b));
            end
            tests_run++;
            if (rl !== 1'b1) begin tests_failed++; $display("FAIL directed_ready_low[%0d] ready_o rose mid-op", i); end
            tests_run++;
            if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL directed_valid_pulse[%0d] got %b want 0", i, valid_o); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] res;
        int lat, seen;
        bit rl;
        run_op(MDU_DIVU, 32'd100, 32'd7, res, lat, rl);
        tests_run++;
        if (res !== 32'd14) begin tests_failed++; $display("FAIL abort_pre_result got %h want 0000000e", res); end
        req_i = 1'b1; mdu_op_i = MDU_DIV; a_i = 32'd1000; b_i = 32'd7;
        @(posedge clk_i); #1;
        req_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1; rst_i = 1'b1; #1;
        tests_run++;
        if (ready_o !== 1'b1) begin tests_failed++; $display("FAIL abort_ready got %b want 1", ready_o); end
        tests_run++;
        if (result_o !== 32'd0) begin tests_failed++; $display("FAIL abort_result got %h want 0", result_o); end
        tests_run++;
        if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL abort_valid got %b want 0", valid_o); end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            if (valid_o) seen++;
            @(posedge clk_i); #1;
        end
        tests_run++;
        if (seen != 0) begin tests_failed++; $display("FAIL abort_no_valid got %0d pulses want 0", seen); end
        run_op(MDU_MUL, 32'd3, 32'd4, res, lat, rl);
        tests_run++;
        if (res !== 32'd12) begin tests_failed++; $display("FAIL abort_next_mul got %h want 0000000c", res); end
        tests_run++;
        if (lat != exp_lat(MDU_MUL, 32'd3, 32'd4)) begin
            tests_failed++; $display("FAIL abort_next_latency got %0d want %0d", lat, exp_lat(MDU_MUL, 32'd3, 32'd4));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, res1, res2;
        int n1, n2;
        logic rdy1;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom | 32'd1;
        n1 = -1; n2 = -1; rdy1 = 1'b0; res1 = 'x; res2 = 'x;
        req_i = 1'b1; mdu_op_i = MDU_MULHU; a_i = a1; b_i = b1;
        @(posedge clk_i); #1;
        mdu_op_i = MDU_REM; a_i = $urandom; b_i = $urandom;
        for (int n = 0; n < 100; n++) begin
            if (valid_o) begin n1 = n; res1 = result_o; break; end
            @(posedge clk_i); #1;
        end
        mdu_op_i = MDU_DIVU; a_i = a2; b_i = b2;
        for (int n = 1; n < 100; n++) begin
            @(posedge clk_i); #1;
            if (n == 1) rdy1 = ready_o;
            if (valid_o) begin n2 = n; res2 = result_o; break; end
        end
        req_i = 1'b0;
        @(posedge clk_i); #1;
        tests_run++;
        if (res1 !== ref_result(MDU_MULHU, a1, b1)) begin
            tests_failed++; $display("FAIL b2b_first_result got %h want %h", res1, ref_result(MDU_MULHU, a1, b1));
        end
        tests_run++;
        if (n1 != exp_lat(MDU_MULHU, a1, b1)) begin
            tests_failed++; $display("FAIL b2b_first_latency got %0d want %0d", n1, exp_lat(MDU_MULHU, a1, b1));
        end
        tests_run++;
        if (rdy1 !== 1'b1) begin tests_failed++; $display("FAIL b2b_idle_ready got %b want 1", rdy1); end
        tests_run++;
        if (n2 != exp_lat(MDU_DIVU, a2, b2) + 2) begin
            tests_failed++; $display("FAIL b2b_second_spacing got %0d want %0d", n2, exp_lat(MDU_DIVU, a2, b2) + 2);
        end
        tests_run++;
        if (res2 !== ref_result(MDU_DIVU, a2, b2)) begin
            tests_failed++; $display("FAIL b2b_second_result got %h want %h", res2, ref_result(MDU_DIVU, a2, b2));
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [2:0] op;
        logic [31:0] a, b, res;
        int lat;
        bit rl;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            run_op(op, a, b, res, lat, rl);
            tests_run++;
            if (res !== ref_result(op, a, b)) begin
                tests_failed++;
                $display("FAIL random_result[%0d] op=%0d a=%h b=%h got %h want %h", i, op, a, b, res, ref_result(op, a, b));
            end
            tests_run++;
            if (lat != exp_lat(op, a, b)) begin
                tests_failed++;
                $display("FAIL random_latency[%0d] op=%0d got %0d want %0d", i, op, lat, exp_lat(op, a, b));
            end
        end
    endtask

`ifdef MDU_EARLY_OUT_EN
    task automatic test_early_out();
        logic [31:0] b, res;
        int lat;
        bit rl;
        b = $urandom | 32'd1;
        run_op(MDU_MUL, 32'd0, b, res, lat, rl);
        tests_run++;
        if (res !== 32'd0) begin tests_failed++; $display("FAIL early_zero_result got %h want 0", res); end
        tests_run++;
        if (lat != 0) begin tests_failed++; $display("FAIL early_zero_latency got %0d want 0", lat); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_back_to_back();
`ifdef MDU_EARLY_OUT_EN
        test_early_out();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
